// File: rtl/contador_param.sv
// rtl/contador_param.sv - per-channel push counter bank with 1-cycle indexed readback
// Optional CONTADOR_SATURATE_EN: counters saturate at 2**CW-1 instead of wrapping.
module contador_param #(
  parameter int N_CH = 5,
  parameter int CW   = 5,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            en,
  input  logic [N_CH-1:0] push,
  input  logic            req,
  input  logic [IDXW-1:0] idx,
  output logic [CW-1:0]   data,
  output logic            valid,
  output logic            err
);

  typedef enum logic [1:0] {INIT, ACTIVE, HOLD} state_t;

  localparam logic [IDXW:0] NCH_W = (IDXW+1)'(N_CH);

  state_t          state, state_nxt;
  logic            count_en, serve;
  logic [CW-1:0]   cnt [N_CH];
  logic [CW-1:0]   rd_val;
  logic            idx_ok;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    state_nxt = en ? ACTIVE : HOLD;
      ACTIVE:  if (!en) state_nxt = HOLD;
      HOLD:    if (en)  state_nxt = ACTIVE;
      default: state_nxt = INIT;
    endcase
  end

  // Counting also requires en, so the cycle en drops never slips in a count.
  always_comb begin
    count_en = 1'b0;
    serve    = 1'b0;
    case (state)
      ACTIVE: begin
        count_en = en;
        serve    = req;
      end
      HOLD:    serve = req;
      default: ;
    endcase
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx == IDXW'(i)) rd_val = cnt[i];
    end
  end

  assign idx_ok = ({1'b0, idx} < NCH_W);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (state == INIT) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (count_en) begin
      for (int i = 0; i < N_CH; i++) begin
        if (push[i]) begin
`ifdef CONTADOR_SATURATE_EN
          if (cnt[i] != {CW{1'b1}}) cnt[i] <= cnt[i] + CW'(1);
`else
          cnt[i] <= cnt[i] + CW'(1);
`endif
        end
      end
    end
  end

  // Read returns the pre-increment value: rd_val comes from the registered counters.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else if (serve) begin
      data  <= idx_ok ? rd_val : '0;
      valid <= 1'b1;
      err   <= ~idx_ok;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_contador_param.sv
// tb/tb_contador_param.sv - directed scoreboard bench for contador_param
module tb_contador_param;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       en;
  logic [4:0] push;
  logic       req;
  logic [2:0] idx;
  logic [4:0] data;
  logic       valid;
  logic       err;

  int tests = 0;
  int fails = 0;
  logic [5:0] exp_q [$];

  contador_param #(.N_CH(5), .CW(5), .IDXW(3)) dut (
    .clk(clk), .reset_L(reset_L), .en(en), .push(push), .req(req), .idx(idx),
    .data(data), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called #1 after the edge that registers a serviced read.
  task automatic expect_rd(input string tag);
    logic [5:0] e;
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(data), 32'(e[4:0]));
      chk({tag, "_err"}, 32'(err), 32'(e[5]));
    end
  endtask

  task automatic rd(input string tag, input int i, input logic [4:0] ed, input logic ee);
    req = 1'b1;
    idx = 3'(i);
    exp_q.push_back({ee, ed});
    cyc();
    req = 1'b0;
    expect_rd(tag);
  endtask

  task automatic pushes(input int ch, input int n);
    push = 5'(1 << ch);
    repeat (n) cyc();
    push = '0;
  endtask

  initial begin
    reset_L = 1'b0; en = 1'b0; push = '0; req = 1'b0; idx = '0;
    repeat (3) cyc();
    chk("rst_data", 32'(data), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_err", 32'(err), 0);

    // Release into INIT with a req and a push that must both be ignored.
    reset_L = 1'b1; en = 1'b1; req = 1'b1; idx = 3'd0; push = 5'b01000;
    cyc();
    push = '0; req = 1'b0;
    chk("init_req_drop", 32'(valid), 0);
    rd("init_push_ignored", 3, 5'd0, 1'b0);

    pushes(2, 7);
    rd("basic_ch2", 2, 5'd7, 1'b0);
    cyc();
    chk("idle_valid", 32'(valid), 0);
    chk("idle_data_hold", 32'(data), 7);
    chk("idle_err", 32'(err), 0);
    rd("basic_ch0", 0, 5'd0, 1'b0);
    rd("basic_ch1", 1, 5'd0, 1'b0);
    rd("basic_ch4", 4, 5'd0, 1'b0);

    pushes(1, 3);
    push = 5'b00010; req = 1'b1; idx = 3'd1;
    exp_q.push_back({1'b0, 5'd3});
    cyc();
    push = '0; req = 1'b0;
    expect_rd("snap_push_rd");
    rd("after_snap", 1, 5'd4, 1'b0);

    pushes(0, 4);
    en = 1'b0;
    cyc();
    pushes(0, 5);
    rd("hold_frozen", 0, 5'd4, 1'b0);
    en = 1'b1;
    cyc();
    pushes(0, 1);
    rd("hold_resume", 0, 5'd5, 1'b0);

    pushes(4, 33);
`ifdef CONTADOR_SATURATE_EN
    rd("overflow", 4, 5'd31, 1'b0);
`else
    rd("overflow", 4, 5'd1, 1'b0);
`endif

    rd("bad_idx", 6, 5'd0, 1'b1);
    rd("bad_idx7", 7, 5'd0, 1'b1);

    req = 1'b1;
    idx = 3'd0; exp_q.push_back({1'b0, 5'd5}); cyc(); expect_rd("b2b_0");
    idx = 3'd1; exp_q.push_back({1'b0, 5'd4}); cyc(); expect_rd("b2b_1");
    idx = 3'd6; exp_q.push_back({1'b1, 5'd0}); cyc(); expect_rd("b2b_6");
    req = 1'b0;
    cyc();
    chk("b2b_end_valid", 32'(valid), 0);
    chk("b2b_end_err", 32'(err), 0);

    // Mid-run async reset: outputs clear at once and the pending read is aborted.
    rd("pre_reset", 2, 5'd7, 1'b0);
    req = 1'b1; idx = 3'd2;
    cyc();
    exp_q.push_back({1'b0, 5'd7});
    expect_rd("pre_reset_b2b");
    #2 reset_L = 1'b0;
    #1;
    chk("async_data", 32'(data), 0);
    chk("async_valid", 32'(valid), 0);
    chk("async_err", 32'(err), 0);
    cyc();
    chk("aborted_valid", 32'(valid), 0);
    req = 1'b0;
    reset_L = 1'b1;
    cyc();
    chk("reinit_valid", 32'(valid), 0);
    rd("cleared_ch2", 2, 5'd0, 1'b0);
    rd("cleared_ch0", 0, 5'd0, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
